// File: rtl/sram_mem_controller.sv
// sram_mem_controller
// Sequences each 32-bit load/store from the MEM stage onto a 16-bit
// asynchronous SRAM as two half-word phases (low half first). ready_o drops
// while an access is in flight so the core can freeze its pipeline and PC.
module sram_mem_controller #(
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en_i,
    input  logic               wr_en_i,
    input  logic [31:0]        address_i,
    input  logic [31:0]        write_data_i,
    output logic [31:0]        read_data_o,
    output logic               ready_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [15:0]        sram_dq_out_o,
    input  logic [15:0]        sram_dq_in_i,
    output logic               sram_dq_oe_o,
    output logic               sram_we_n_o
);

    // Counter only needs to reach WAIT_CYCLES-1 (WAIT_CYCLES is at least 2).
    localparam int unsigned    CW       = $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SRAM_AW-2:0] off_q, off_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               last_cnt;
    logic               req;

    assign last_cnt    = (cnt_q == CNT_LAST);
    assign req         = wr_en_i | rd_en_i;
    assign read_data_o = rdata_q;

    // State, phase counter and latched request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic plus the SRAM bus / ready outputs decoded from state.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        off_d         = off_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        ready_o       = 1'b0;
        sram_addr_o   = '0;
        sram_dq_out_o = '0;
        sram_dq_oe_o  = 1'b0;
        sram_we_n_o   = 1'b1;

        // Every access state runs the same 0..WAIT_CYCLES-1 count.
        if (state_q != IDLE && state_q != DONE) begin
            cnt_d = last_cnt ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                ready_o = ~req;
                if (req) begin
                    // Word offset wraps modulo the SRAM size; no range check.
                    off_d   = (SRAM_AW-1)'((address_i - 32'(ADDR_BASE)) >> 2);
                    wdata_d = write_data_i;
                    cnt_d   = '0;
                    // A simultaneous read is dropped in favour of the write.
                    state_d = wr_en_i ? WR_LO : RD_LO;
                end
            end
            WR_LO: begin
                sram_addr_o   = {off_q, 1'b0};
                sram_dq_out_o = wdata_q[15:0];
                sram_dq_oe_o  = 1'b1;
                // Strobe released on the last cycle to give address/data hold.
                sram_we_n_o   = last_cnt;
                if (last_cnt) state_d = WR_HI;
            end
            WR_HI: begin
                sram_addr_o   = {off_q, 1'b1};
                sram_dq_out_o = wdata_q[31:16];
                sram_dq_oe_o  = 1'b1;
                sram_we_n_o   = last_cnt;
                if (last_cnt) state_d = DONE;
            end
            RD_LO: begin
                sram_addr_o = {off_q, 1'b0};
                if (last_cnt) begin
                    rdata_d[15:0] = sram_dq_in_i;
                    state_d       = RD_HI;
                end
            end
            RD_HI: begin
                sram_addr_o = {off_q, 1'b1};
                if (last_cnt) begin
                    rdata_d[31:16] = sram_dq_in_i;
                    state_d        = DONE;
                end
            end
            DONE: begin
                // The request may still be high here; it is the one just
                // finished, so always return to IDLE rather than restarting.
                ready_o = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Testbench for sram_mem_controller: two instances (WAIT_CYCLES 2 and 4),
// each attached to a behavioural async SRAM. Stimulus pushes expected
// results into per-instance queues; a monitor per instance pops and checks
// at each DONE cycle (ready returning high after a freeze).
module tb_sram_mem_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [2];
    logic        rd_en      [2];
    logic        wr_en      [2];
    logic [31:0] address    [2];
    logic [31:0] write_data [2];
    logic [31:0] read_data  [2];
    logic        ready      [2];
    logic [17:0] sram_addr  [2];
    logic [15:0] dq_out     [2];
    logic        oe         [2];
    logic        we_n       [2];

    typedef struct {
        logic        wr;
        int          off;
        logic [31:0] data;
        logic [31:0] exp_rd;
        int          gap;
    } exp_t;

    exp_t        exp_q [2][$];
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd [2];
    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input int inst,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %h expected %h", name, inst, act, exp);
        end
    endfunction

    // Word offset from the address map: (addr - base)/4 modulo 2^17 words.
    function automatic int off_of(input logic [31:0] a);
        return int'(((a - 32'd1024) >> 2) & 32'h1FFFF);
    endfunction

    function automatic int wait_of(input int s);
        return (s == 0) ? 2 : 4;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int W = (gi == 0) ? 2 : 4;
        logic [15:0] mem [0:262143];
        logic [15:0] dq_in;

        sram_mem_controller #(
            .ADDR_BASE  (1024),
            .SRAM_AW    (18),
            .WAIT_CYCLES(W)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[gi]),
            .rd_en_i      (rd_en[gi]),
            .wr_en_i      (wr_en[gi]),
            .address_i    (address[gi]),
            .write_data_i (write_data[gi]),
            .read_data_o  (read_data[gi]),
            .ready_o      (ready[gi]),
            .sram_addr_o  (sram_addr[gi]),
            .sram_dq_out_o(dq_out[gi]),
            .sram_dq_in_i (dq_in),
            .sram_dq_oe_o (oe[gi]),
            .sram_we_n_o  (we_n[gi])
        );

        // Async SRAM: cell follows the bus while the strobe is low.
        always @(posedge clk) begin
            if (!we_n[gi] && oe[gi]) mem[sram_addr[gi]] <= dq_out[gi];
        end
        assign dq_in = mem[sram_addr[gi]];

        // Monitor: measure each freeze and check it when DONE appears.
        initial begin
            int k = 0, wl = 0, oec = 0, ones = 1000, gap = 0;
            bit busy = 0;
            logic [17:0] a_lo = '0, a_hi = '0;
            logic [15:0] d_lo = '0, d_hi = '0;
            exp_t e;
            forever begin
                @(negedge clk);
                if (!rst_n[gi]) begin
                    busy = 0;
                    ones = 1000;
                end else if (!ready[gi]) begin
                    if (!busy) begin
                        busy = 1; k = 0; wl = 0; oec = 0; gap = ones;
                    end
                    k++;
                    if (!we_n[gi]) wl++;
                    if (oe[gi]) oec++;
                    if (k == 2) begin a_lo = sram_addr[gi]; d_lo = dq_out[gi]; end
                    if (k == 2*W + 1) begin a_hi = sram_addr[gi]; d_hi = dq_out[gi]; end
                end else if (busy) begin
                    busy = 0;
                    ones = 1;
                    if (exp_q[gi].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_access inst%0d got access of %0d cycles required none", gi, k);
                    end else begin
                        e = exp_q[gi].pop_front();
                        chk("freeze_len", gi, k, 1 + 2*W);
                        chk("we_low_cycles", gi, wl, e.wr ? 2*(W-1) : 0);
                        chk("oe_cycles", gi, oec, e.wr ? 2*W : 0);
                        chk("addr_lo", gi, 32'(a_lo), 2*e.off);
                        chk("addr_hi", gi, 32'(a_hi), 2*e.off + 1);
                        if (e.wr) begin
                            chk("dq_out_lo", gi, 32'(d_lo), 32'(e.data[15:0]));
                            chk("dq_out_hi", gi, 32'(d_hi), 32'(e.data[31:16]));
                            chk("sram_lo", gi, 32'(mem[2*e.off]), 32'(e.data[15:0]));
                            chk("sram_hi", gi, 32'(mem[2*e.off+1]), 32'(e.data[31:16]));
                        end
                        chk("read_data", gi, read_data[gi], e.exp_rd);
                        if (e.gap >= 0) chk("ready_gap", gi, gap, e.gap);
                        $display("txn inst%0d %s off=%05h data=%08h read_data=%08h freeze=%0d",
                                 gi, e.wr ? "WR" : "RD", e.off, e.data, read_data[gi], k);
                    end
                end else begin
                    ones++;
                end
            end
        end
    end

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Issue one access (called at posedge+1), hold it until DONE, then drop.
    task automatic do_access(input int s, input logic wr, input logic rd,
                             input logic [31:0] addr, input logic [31:0] data,
                             input int exp_gap);
        exp_t e;
        int key;
        int n;
        e.wr   = wr;
        e.off  = off_of(addr);
        e.data = data;
        e.gap  = exp_gap;
        key    = s * 131072 + e.off;
        if (wr) begin
            ref_mem[key] = data;
            e.exp_rd     = last_rd[s];
        end else begin
            e.exp_rd   = ref_mem[key];
            last_rd[s] = e.exp_rd;
        end
        exp_q[s].push_back(e);
        wr_en[s]      = wr;
        rd_en[s]      = rd;
        address[s]    = addr;
        write_data[s] = data;
        @(posedge clk);
        #1;
        // The request is latched by now; later input changes must not matter.
        address[s]    = $urandom;
        write_data[s] = $urandom;
        n = 0;
        while (!ready[s] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL done_timeout inst%0d got no DONE within %0d cycles required completion", s, n);
        end
        @(posedge clk);
        #1;
        wr_en[s] = 1'b0;
        rd_en[s] = 1'b0;
    endtask

    // Start a store, then reset during the first cycle of its high phase.
    task automatic reset_mid_write(input int s, input logic [31:0] addr,
                                   input logic [31:0] data);
        wr_en[s]      = 1'b1;
        address[s]    = addr;
        write_data[s] = data;
        repeat (wait_of(s) + 1) @(posedge clk);
        #3;
        chk("pre_rst_addr_hi", s, 32'(sram_addr[s]), 2*off_of(addr) + 1);
        rst_n[s] = 1'b0;
        wr_en[s] = 1'b0;
        #1;
        chk("rst_async_addr", s, 32'(sram_addr[s]), 0);
        chk("rst_async_dq_out", s, 32'(dq_out[s]), 0);
        chk("rst_async_oe", s, 32'(oe[s]), 0);
        chk("rst_async_we_n", s, 32'(we_n[s]), 1);
        chk("rst_async_read_data", s, read_data[s], 0);
        chk("rst_async_ready", s, 32'(ready[s]), 1);
        last_rd[s] = '0;
        @(posedge clk);
        #1;
        rst_n[s] = 1'b1;
    endtask

    task automatic directed(input int s);
        do_access(s, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, -1);
        idle(2);
        do_access(s, 1'b0, 1'b1, 32'd1024, 32'h0, -1);
        idle(1);
        do_access(s, 1'b1, 1'b0, 32'd1028, 32'h12345678, -1);
        do_access(s, 1'b0, 1'b1, 32'd1028, 32'h0, 1);
        idle(1);
        do_access(s, 1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, -1);
        idle(1);
        // Below ADDR_BASE wraps to the top of the SRAM.
        do_access(s, 1'b1, 1'b0, 32'd1020, 32'hCAFE0001, -1);
        do_access(s, 1'b0, 1'b1, 32'd1020, 32'h0, 1);
        idle(2);
        reset_mid_write(s, 32'd1036, 32'h0BADF00D);
        do_access(s, 1'b1, 1'b0, 32'd1036, 32'h13579BDF, -1);
        do_access(s, 1'b0, 1'b1, 32'd1036, 32'h0, 1);
        idle(2);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; rd_en[i] = 1'b0; wr_en[i] = 1'b0;
            address[i] = '0; write_data[i] = '0; last_rd[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_ready", s, 32'(ready[s]), 1);
            chk("rst_read_data", s, read_data[s], 0);
            chk("rst_addr", s, 32'(sram_addr[s]), 0);
            chk("rst_dq_out", s, 32'(dq_out[s]), 0);
            chk("rst_oe", s, 32'(oe[s]), 0);
            chk("rst_we_n", s, 32'(we_n[s]), 1);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        idle(2);

        directed(0);
        directed(1);

        begin
            int prev_s = -1;
            for (int t = 0; t < 40; t++) begin
                int s, idx, g, key, op;
                logic [31:0] addr;
                s   = int'($urandom_range(0, 1));
                idx = int'($urandom_range(0, 17));
                if (idx == 16)      addr = 32'd1020;
                else if (idx == 17) addr = 32'd1024 + (32'd1 << 19) + 32'd8;
                else                addr = 32'd1024 + 32'(4 * idx);
                key = s * 131072 + off_of(addr);
                op  = ref_mem.exists(key) ? int'($urandom_range(0, 2)) : 0;
                g   = int'($urandom_range(0, 2));
                idle(g);
                do_access(s, (op != 1), (op != 0), addr, $urandom,
                          (s == prev_s) ? 1 + g : -1);
                prev_s = s;
            end
        end

        idle(5);
        for (int s = 0; s < 2; s++) chk("queue_empty", s, exp_q[s].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
